// File: rtl/keypad_scan_ctrl.sv
// Scan controller for a 4x4 active-low matrix keypad: rotates the column drive, debounces
// press and release, and reports one key_valid pulse per accepted press.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV  = 16,
    parameter int DB_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows_sync,
    output logic [3:0] cols,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST    = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    state_t          state;
    logic [1:0]      col_idx;
    logic [1:0]      row_idx;
    logic [DW-1:0]   dwell;
    logic [CW-1:0]   db_cnt;

    logic            any_low;
    logic [1:0]      low_row;
    logic            row_open;

    function automatic logic [3:0] col_drive(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

    // Priority encoder: scanning from the top down lets the lowest low row overwrite last.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        low_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!rows_sync[r]) low_row = 2'(r);
        end
        any_low  = ~&rows_sync;
        row_open = rows_sync[row_idx];
    end

    // NOTE: all state and outputs update with non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            dwell     <= '0;
            db_cnt    <= '0;
            cols      <= 4'b1110;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (dwell == DWELL_LAST) begin
                        if (any_low) begin
                            row_idx <= low_row;
                            db_cnt  <= '0;
                            state   <= DEBOUNCE;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                            cols    <= col_drive(col_idx + 2'd1);
                            dwell   <= '0;
                        end
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (!row_open) begin
                        if (db_cnt == DB_LAST) begin
                            state     <= HELD;
                            key_valid <= 1'b1;
                            key_code  <= {row_idx, col_idx};
                            key_held  <= 1'b1;
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end else begin
                        // Bounce: resume scanning on the same column with a fresh dwell.
                        state <= SCAN;
                        dwell <= '0;
                    end
                end
                HELD: begin
                    if (row_open) begin
                        db_cnt <= '0;
                        state  <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (row_open) begin
                        if (db_cnt == DB_LAST) begin
                            key_held <= 1'b0;
                            col_idx  <= col_idx + 2'd1;
                            cols     <= col_drive(col_idx + 2'd1);
                            dwell    <= '0;
                            state    <= SCAN;
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end else begin
                        state <= HELD;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl with SCAN_DIV=4, DB_CYCLES=8: a keypad model drives the rows,
// a vector table covers the idle scan and a scoreboard checks every key_valid pulse.
module tb_keypad_scan_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] rows_sync;
    logic [3:0] cols;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    logic [3:0] keys [4];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic       rst;
        logic [3:0] cols;
        logic       valid;
        logic       held;
        logic [3:0] code;
    } vec_t;

    typedef struct {
        logic [3:0] code;
        int         due;
    } exp_t;

    vec_t vecs [17];
    exp_t sb [$];

    keypad_scan_ctrl #(.SCAN_DIV(4), .DB_CYCLES(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .rows_sync (rows_sync),
        .cols      (cols),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A pressed key pulls its row low only while its column is driven.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            rows_sync[r] = ~|(keys[r] & ~cols);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock; outputs are sampled on the falling edge and pulses go through the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (key_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_key_valid", 32'(key_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("kv_code", 32'(key_code), 32'(e.code));
                check("kv_cycle", 32'(cyc), 32'(e.due));
            end
        end else if (sb.size() != 0 && cyc > sb[0].due) begin
            check("kv_missing", 32'(key_valid), 32'd1);
            void'(sb.pop_front());
        end
    endtask

    task automatic wait_cols(input logic [3:0] target);
        int n = 0;
        while (cols !== target && n < 64) begin
            tick();
            n++;
        end
        check("wait_cols", 32'(cols), 32'(target));
    endtask

    task automatic clear_keys();
        for (int r = 0; r < 4; r++) keys[r] = 4'b0000;
    endtask

    initial begin
        logic [3:0] scan_seq [5];
        scan_seq[0] = 4'b1110;
        scan_seq[1] = 4'b1101;
        scan_seq[2] = 4'b1011;
        scan_seq[3] = 4'b0111;
        scan_seq[4] = 4'b1110;
        for (int n = 0; n < 17; n++) begin
            vecs[n].rst   = (n == 0);
            vecs[n].cols  = scan_seq[n / 4];
            vecs[n].valid = 1'b0;
            vecs[n].held  = 1'b0;
            vecs[n].code  = 4'h0;
        end

        clear_keys();
        reset = 1'b1;

        // Reset and idle scan: four cycles per column, wrapping back to column 0.
        for (int n = 0; n < 17; n++) begin
            reset = vecs[n].rst;
            tick();
            check($sformatf("scan_cols[%0d]", n), 32'(cols), 32'(vecs[n].cols));
            check($sformatf("scan_valid[%0d]", n), 32'(key_valid), 32'(vecs[n].valid));
            check($sformatf("scan_held[%0d]", n), 32'(key_held), 32'(vecs[n].held));
            check($sformatf("scan_code[%0d]", n), 32'(key_code), 32'(vecs[n].code));
        end

        // Press (row2,col1): pulse 9 cycles after the col1 sample, i.e. 12 after col1 starts.
        keys[2][1] = 1'b1;
        wait_cols(4'b1101);
        sb.push_back('{code: 4'b1001, due: cyc + 12});
        for (int i = 0; i < 40; i++) begin
            tick();
            check("press_cols_frozen", 32'(cols), 32'(4'b1101));
        end
        check("press_held", 32'(key_held), 32'd1);
        check("press_code", 32'(key_code), 32'(4'b1001));
        check("press_sb_empty", 32'(sb.size()), 32'd0);

        // Release with two short glitches, then a clean release.
        keys[2][1] = 1'b0;
        repeat (3) begin tick(); check("glitch_held", 32'(key_held), 32'd1); end
        keys[2][1] = 1'b1;
        repeat (2) begin tick(); check("glitch_held", 32'(key_held), 32'd1); end
        keys[2][1] = 1'b0;
        repeat (5) begin tick(); check("glitch_held", 32'(key_held), 32'd1); end
        keys[2][1] = 1'b1;
        repeat (3) begin tick(); check("glitch_held", 32'(key_held), 32'd1); end
        keys[2][1] = 1'b0;
        repeat (8) begin tick(); check("release_held", 32'(key_held), 32'd1); end
        tick();
        check("release_dropped", 32'(key_held), 32'd0);
        check("release_next_col", 32'(cols), 32'(4'b1011));

        // Bounce on (row0,col3): aborted debounce, scan resumes on col3 with a full dwell.
        wait_cols(4'b0111);
        keys[0][3] = 1'b1;
        repeat (3) tick();
        check("bounce_sample_cols", 32'(cols), 32'(4'b0111));
        repeat (3) tick();
        keys[0][3] = 1'b0;
        tick();
        check("bounce_cols", 32'(cols), 32'(4'b0111));
        check("bounce_held", 32'(key_held), 32'd0);
        check("bounce_code_kept", 32'(key_code), 32'(4'b1001));
        repeat (3) tick();
        check("bounce_dwell_end", 32'(cols), 32'(4'b0111));
        tick();
        check("bounce_wrap", 32'(cols), 32'(4'b1110));

        // Two keys on col2: row1 wins; a later key elsewhere is ignored while held.
        wait_cols(4'b1101);
        keys[1][2] = 1'b1;
        keys[3][2] = 1'b1;
        wait_cols(4'b1011);
        sb.push_back('{code: 4'b0110, due: cyc + 12});
        repeat (14) tick();
        check("multi_held", 32'(key_held), 32'd1);
        check("multi_code", 32'(key_code), 32'(4'b0110));
        keys[0][0] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            check("ignore_cols", 32'(cols), 32'(4'b1011));
            check("ignore_held", 32'(key_held), 32'd1);
        end
        check("multi_sb_empty", 32'(sb.size()), 32'd0);

        // Reset while held, then a fresh press must still debounce normally.
        reset = 1'b1;
        tick();
        check("rst_cols", 32'(cols), 32'(4'b1110));
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_held", 32'(key_held), 32'd0);
        reset = 1'b0;
        clear_keys();
        repeat (20) begin tick(); check("post_rst_held", 32'(key_held), 32'd0); end
        wait_cols(4'b0111);
        keys[3][0] = 1'b1;
        wait_cols(4'b1110);
        sb.push_back('{code: 4'b1100, due: cyc + 12});
        repeat (14) tick();
        check("fresh_held", 32'(key_held), 32'd1);
        check("fresh_code", 32'(key_code), 32'(4'b1100));
        keys[3][0] = 1'b0;
        repeat (12) tick();
        check("fresh_released", 32'(key_held), 32'd0);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
